// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush controller for the 5-stage RV64 pipeline: load-use
//            stalls, taken-branch flushes, data-memory freeze with timeout,
//            and saturating stall/flush performance counters.
// Revision : 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_write,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic timeout;
    logic freeze;
    logic load_use;
    logic branch_flush;

    assign timeout  = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LIMIT);
    assign freeze   = mem_req && !mem_ack && !timeout;
    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    assign branch_flush = !reset && !freeze && mem_branch_taken;

    // Pipeline controls: reset > freeze > branch flush > load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (mem_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // wait_cnt counts frozen cycles so far, so the forced release lands on
    // the cycle after MEM_TIMEOUT-1 frozen cycles.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_err_d   = mem_err_q | timeout;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Brief    : Directed plus random bench for pipeline_hazard_ctrl, checked
//            against a cycle-level behavioural model of the control rules.
// Revision : 1.0
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs2, ex_memread, mem_branch_taken, mem_req, mem_ack;
    logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic             ex_mem_write, ex_mem_flush, mem_wb_write, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: consecutive frozen cycles, sticky error, counters.
    int frozen_run = 0;
    bit m_err      = 1'b0;
    int m_stall    = 0;
    int m_flush    = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mem_wb_write(mem_wb_write), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
        ex_memread = 1'b0; mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // Check one cycle at the falling edge, then advance the model on the rising edge.
    task automatic run_cycle(input string tag);
        bit to, fz, hz, br;
        bit e_pc, e_ifw, e_idw, e_exw, e_wbw, e_iff, e_idf, e_exf;
        @(negedge clk);
        to = (frozen_run == MEM_TIMEOUT - 1);
        fz = mem_req && !mem_ack && !to;
        hz = ex_memread && (ex_rd != 0) &&
             ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        br = mem_branch_taken;
        if (reset) begin
            {e_pc, e_ifw, e_idw, e_exw, e_wbw} = 5'b00000;
            {e_iff, e_idf, e_exf} = 3'b111;
        end else if (fz) begin
            {e_pc, e_ifw, e_idw, e_exw, e_wbw} = 5'b00000;
            {e_iff, e_idf, e_exf} = 3'b000;
        end else begin
            {e_pc, e_ifw, e_idw, e_exw, e_wbw} = 5'b11111;
            {e_iff, e_idf, e_exf} = br ? 3'b111 : 3'b000;
            if (!br && hz) begin
                e_pc = 1'b0; e_ifw = 1'b0; e_idf = 1'b1;
            end
        end
        chk({tag, ".pc_write"},     64'(pc_write),     64'(e_pc));
        chk({tag, ".if_id_write"},  64'(if_id_write),  64'(e_ifw));
        chk({tag, ".id_ex_write"},  64'(id_ex_write),  64'(e_idw));
        chk({tag, ".ex_mem_write"}, 64'(ex_mem_write), 64'(e_exw));
        chk({tag, ".mem_wb_write"}, 64'(mem_wb_write), 64'(e_wbw));
        chk({tag, ".if_id_flush"},  64'(if_id_flush),  64'(e_iff));
        chk({tag, ".id_ex_flush"},  64'(id_ex_flush),  64'(e_idf));
        chk({tag, ".ex_mem_flush"}, 64'(ex_mem_flush), 64'(e_exf));
        chk({tag, ".mem_err"},      64'(mem_err),      64'(m_err));
        chk({tag, ".stall_cnt"},    64'(stall_cnt),    64'(m_stall));
        chk({tag, ".flush_cnt"},    64'(flush_cnt),    64'(m_flush));
        @(posedge clk);
        if (reset) begin
            frozen_run = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (to) m_err = 1'b1;
            frozen_run = fz ? frozen_run + 1 : 0;
            if (!e_pc && m_stall < CNT_MAX) m_stall++;
            if (!fz && br && m_flush < CNT_MAX) m_flush++;
        end
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        run_cycle("reset");
        run_cycle("reset");
        reset = 1'b0;
        run_cycle("idle");
        run_cycle("idle");
        chk("idle.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("idle.flush_cnt", 64'(flush_cnt), 64'd0);
        chk("idle.mem_err",   64'(mem_err),   64'd0);

        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        run_cycle("lu_rs1");
        chk("lu_rs1.stall_cnt", 64'(stall_cnt), 64'd1);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        run_cycle("lu_x0");
        chk("lu_x0.stall_cnt", 64'(stall_cnt), 64'd1);

        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs1 = 5'd1;
        run_cycle("lu_rs2_unused");
        id_uses_rs2 = 1'b1;
        run_cycle("lu_rs2_used");
        chk("lu_rs2.stall_cnt", 64'(stall_cnt), 64'd2);

        idle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; mem_branch_taken = 1'b1;
        run_cycle("branch_lu");
        chk("branch.flush_cnt", 64'(flush_cnt), 64'd1);
        chk("branch.stall_cnt", 64'(stall_cnt), 64'd2);

        idle();
        mem_req = 1'b1; mem_branch_taken = 1'b1;
        repeat (3) run_cycle("freeze3");
        chk("freeze3.flush_cnt", 64'(flush_cnt), 64'd1);
        mem_ack = 1'b1;
        run_cycle("ack");
        chk("ack.stall_cnt", 64'(stall_cnt), 64'd5);
        chk("ack.flush_cnt", 64'(flush_cnt), 64'd2);

        idle();
        mem_req = 1'b1;
        repeat (MEM_TIMEOUT) run_cycle("timeout");
        chk("timeout.stall_cnt", 64'(stall_cnt), 64'd20);
        chk("timeout.mem_err",   64'(mem_err),   64'd1);
        mem_req = 1'b0;
        repeat (2) run_cycle("err_hold");
        mem_req = 1'b1;
        repeat (5) run_cycle("wait2");
        reset = 1'b1;
        run_cycle("reset_mid_wait");
        reset = 1'b0;
        chk("rst_wait.mem_err",   64'(mem_err),   64'd0);
        chk("rst_wait.stall_cnt", 64'(stall_cnt), 64'd0);
        repeat (MEM_TIMEOUT + 2) run_cycle("post_reset_wait");

        for (int i = 0; i < 400; i++) begin
            reset            = ($urandom_range(49) == 0);
            id_rs1           = 5'($urandom_range(3));
            id_rs2           = 5'($urandom_range(3));
            ex_rd            = 5'($urandom_range(3));
            id_uses_rs2      = 1'($urandom_range(1));
            ex_memread       = 1'($urandom_range(1));
            mem_branch_taken = ($urandom_range(4) == 0);
            mem_req          = ($urandom_range(2) == 0);
            mem_ack          = ($urandom_range(9) < 4);
            run_cycle("random");
        end

        idle();
        reset = 1'b0;
        mem_req = 1'b1;
        repeat (300) run_cycle("stall_sat");
        chk("stall_sat.stall_cnt", 64'(stall_cnt), 64'(CNT_MAX));
        idle();
        mem_branch_taken = 1'b1;
        repeat (300) run_cycle("flush_sat");
        chk("flush_sat.flush_cnt", 64'(flush_cnt), 64'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
